puf_challenge_sequencer: RTL and testbench

//  Upstream driver and downstream collector for the 8-bit arbiter PUF.
//  - Sweeps all 2^CH_W challenges and launches one race per evaluation.
//  - Samples the arbiter response and majority-votes VOTES evaluations per challenge.
//  - Packs voted bits LSB-first into bytes and streams them out on a valid/ready port.
//  - Counts unstable (non-unanimous) challenges for reliability characterisation.

---
 rtl/puf_pkg.sv | 16 +
 rtl/puf_resp_sync.sv | 21 ++
 rtl/puf_challenge_sequencer.sv | 145 ++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and widths for the arbiter-PUF challenge sequencer.
package puf_pkg;
    localparam int PUF_BYTE_W = 8;
    localparam int VOTE_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_LAUNCH,
        ST_SETTLE,
        ST_SAMPLE,
        ST_VOTE,
        ST_EMIT,
        ST_FIN
    } state_t;
endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer bringing the asynchronous arbiter response into the clk domain.
module puf_resp_sync
    import puf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sweeps every challenge, majority-votes repeated arbiter races and streams packed bytes
// out on a valid/ready port while counting non-unanimous challenges.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int CH_W       = 8,
    parameter int SETTLE_CYC = 16,
    parameter int VOTES      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [CH_W-1:0]       puf_ch,
    output logic                  puf_rst,
    output logic                  puf_launch,
    input  logic                  puf_resp,
    output logic [PUF_BYTE_W-1:0] resp_byte,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CH_W:0]         unstable_cnt
);
    localparam int SET_W = $clog2(SETTLE_CYC);
    localparam logic [SET_W-1:0]      SETTLE_LAST = SET_W'(SETTLE_CYC - 2);
    localparam logic [VOTE_CNT_W-1:0] VOTES_N     = VOTE_CNT_W'(VOTES);
    localparam logic [VOTE_CNT_W-1:0] VOTES_HALF  = VOTE_CNT_W'(VOTES / 2);
    localparam logic [CH_W:0]         UNST_MAX    = {1'b1, {CH_W{1'b0}}};
    localparam logic [CH_W-1:0]       CH_LAST     = {CH_W{1'b1}};

    // Output handshake: a byte transfers on every rising edge where resp_valid && resp_ready;
    // resp_byte is held constant from the rise of resp_valid until that edge.

    state_t                  state;
    state_t                  state_next;
    logic                    sync_resp;
    logic [SET_W-1:0]        settle_cnt;
    logic [VOTE_CNT_W-1:0]   ones;
    logic [VOTE_CNT_W-1:0]   evals;
    logic [PUF_BYTE_W-1:0]   pack;
    logic [PUF_BYTE_W-1:0]   pack_next;
    logic                    voted_bit;
    logic                    handshake;
    logic                    byte_full;

    puf_resp_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (puf_resp),
        .q   (sync_resp)
    );

    always_comb begin
        voted_bit = (ones > VOTES_HALF);
        pack_next = pack;
        pack_next[puf_ch[2:0]] = voted_bit;
        handshake = resp_valid && resp_ready;
        byte_full = (puf_ch[2:0] == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        puf_rst    = 1'b0;
        puf_launch = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                puf_rst = 1'b1;
                if (start) state_next = ST_ARM;
            end
            ST_ARM: begin
                puf_rst    = 1'b1;
                state_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                puf_launch = 1'b1;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = (evals < VOTES_N - 1'b1) ? ST_ARM : ST_VOTE;
            ST_VOTE:   state_next = byte_full ? ST_EMIT : ST_ARM;
            ST_EMIT:   if (handshake) state_next = (puf_ch == CH_LAST) ? ST_FIN : ST_ARM;
            ST_FIN: begin
                puf_rst    = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            puf_ch       <= '0;
            resp_byte    <= '0;
            resp_valid   <= 1'b0;
            busy         <= 1'b0;
            unstable_cnt <= '0;
            settle_cnt   <= '0;
            ones         <= '0;
            evals        <= '0;
            pack         <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    puf_ch       <= '0;
                    unstable_cnt <= '0;
                    pack         <= '0;
                    busy         <= 1'b1;
                end
                ST_LAUNCH: settle_cnt <= '0;
                ST_SETTLE: settle_cnt <= settle_cnt + 1'b1;
                ST_SAMPLE: begin
                    ones  <= ones + {{(VOTE_CNT_W-1){1'b0}}, sync_resp};
                    evals <= evals + 1'b1;
                end
                ST_VOTE: begin
                    pack  <= pack_next;
                    ones  <= '0;
                    evals <= '0;
                    if (ones != '0 && ones != VOTES_N && unstable_cnt != UNST_MAX)
                        unstable_cnt <= unstable_cnt + 1'b1;
                    // Byte is complete once the bit at position 7 lands; hand it out directly.
                    if (byte_full) begin
                        resp_byte  <= pack_next;
                        resp_valid <= 1'b1;
                    end else begin
                        puf_ch <= puf_ch + 1'b1;
                    end
                end
                ST_EMIT: if (handshake) begin
                    resp_valid <= 1'b0;
                    if (puf_ch != CH_LAST) puf_ch <= puf_ch + 1'b1;
                end
                ST_FIN: busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench: behavioural PUF model, byte scoreboard and immediate-assertion checks.
module tb_puf_challenge_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       puf_resp = 1'b0;
    logic       resp_ready = 1'b1;
    logic [7:0] puf_ch;
    logic       puf_rst;
    logic       puf_launch;
    logic [7:0] resp_byte;
    logic       resp_valid;
    logic       busy;
    logic       done;
    logic [8:0] unstable_cnt;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    int         byte_cnt = 0;
    int         done_cnt = 0;
    int         launch_cnt = 0;
    int         mode = 0;
    int         tog_idx = 0;
    logic [4:0] tog_pat = 5'b01101;

    always #5 clk = ~clk;

    puf_challenge_sequencer #(.CH_W(8), .SETTLE_CYC(16), .VOTES(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .puf_ch       (puf_ch),
        .puf_rst      (puf_rst),
        .puf_launch   (puf_launch),
        .puf_resp     (puf_resp),
        .resp_byte    (resp_byte),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .done         (done),
        .unstable_cnt (unstable_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // PUF model: the arbiter clears under puf_rst and resolves on the launch edge.
    always @(negedge clk) begin
        if (puf_rst) begin
            puf_resp = 1'b0;
        end else if (puf_launch) begin
            case (mode)
                1: puf_resp = ^puf_ch;
                2: if (puf_ch == 8'd3) begin
                    puf_resp = tog_pat[tog_idx % 5];
                    tog_idx++;
                end else begin
                    puf_resp = puf_ch[0];
                end
                default: puf_resp = puf_ch[0];
            endcase
        end
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", {24'h0, resp_byte}, 32'h0)
                ;
                else check("resp_byte", {24'h0, resp_byte}, {24'h0, exp_q.pop_front()});
                byte_cnt++;
            end
            if (done) done_cnt++;
            if (puf_launch) launch_cnt++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_bytes(input int target, input int budget, input string tag);
        int n = 0;
        while (byte_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, byte_cnt, target);
    endtask

    initial begin
        int base;
        int lat;
        int n;
        int lc;
        int dc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_puf_rst", puf_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_unstable", unstable_cnt, 0);
        check("rst_puf_ch", puf_ch, 0);
        check("rst_launch", puf_launch, 0);
        check("rst_byte", resp_byte, 0);
        rst = 1'b0;

        // Full sweep, stable response = ch[0]
        mode = 0;
        for (int i = 0; i < 32; i++) exp_q.push_back(8'hAA);
        pulse_start();
        check("sweep_busy", busy, 1);
        wait_bytes(32, 25000, "sweep_bytes");
        n = 0;
        while (done_cnt < 1 && n < 20) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        check("sweep_done_once", done_cnt, 1);
        check("sweep_busy_end", busy, 0);
        check("sweep_unstable", unstable_cnt, 0);
        check("sweep_last_ch", puf_ch, 8'hFF);
        check("sweep_queue_empty", exp_q.size(), 0);

        // Parity response and first-byte latency
        mode = 1;
        base = byte_cnt;
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h69);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
        check("first_valid_latency", lat, 729);
        wait_bytes(base + 2, 2000, "parity_bytes");
        do_reset();

        // Unstable challenge 3
        mode = 2;
        tog_idx = 0;
        base = byte_cnt;
        exp_q.push_back(8'hAA);
        pulse_start();
        wait_bytes(base + 1, 2000, "toggle_byte");
        check("toggle_unstable", unstable_cnt, 1);
        check("toggle_evals_ch3", tog_idx, 5);
        do_reset();

        // Backpressure on byte 0
        mode = 0;
        resp_ready = 1'b0;
        base = byte_cnt;
        exp_q.push_back(8'hAA);
        pulse_start();
        n = 0;
        while (!resp_valid && n < 2000) begin @(posedge clk); #1; n++; end
        check("stall_valid_seen", resp_valid, 1);
        lc = launch_cnt;
        repeat (40) begin
            @(posedge clk); #1;
            check("stall_byte", resp_byte, 8'hAA);
            check("stall_valid", resp_valid, 1);
        end
        check("stall_no_launch", launch_cnt, lc);
        resp_ready = 1'b1;
        wait_bytes(base + 1, 10, "stall_release");
        repeat (30) @(posedge clk);
        #1;
        check("stall_resume", launch_cnt > lc, 1);
        do_reset();

        // Reset during SETTLE of challenge 100
        mode = 0;
        base = byte_cnt;
        dc = done_cnt;
        for (int i = 0; i < 12; i++) exp_q.push_back(8'hAA);
        pulse_start();
        n = 0;
        while (puf_ch != 8'd100 && n < 10000) begin @(posedge clk); #1; n++; end
        check("abort_reach_ch100", puf_ch, 100);
        n = 0;
        while (!puf_launch && n < 50) begin @(posedge clk); #1; n++; end
        check("abort_launch_seen", puf_launch, 1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("abort_puf_ch", puf_ch, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", resp_valid, 0);
        check("abort_byte", resp_byte, 0);
        check("abort_puf_rst", puf_rst, 1);
        check("abort_bytes", byte_cnt - base, 12);
        check("abort_queue_empty", exp_q.size(), 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, dc);
        exp_q.push_back(8'hAA);
        pulse_start();
        check("restart_ch", puf_ch, 0);
        check("restart_busy", busy, 1);
        wait_bytes(base + 13, 2000, "restart_byte");
        check("restart_no_done", done_cnt, dc);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
